// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the MIPS pipeline hazard controller.
package pipe_ctrl_pkg;

  typedef enum logic {
    IDLE,
    BUSY
  } md_state_t;

  typedef enum logic [1:0] {
    HZ_NONE,
    HZ_REDIRECT,
    HZ_LOAD,
    HZ_MD
  } hazard_t;

  localparam logic [31:0] NOP_INSTR = 32'h0;

endpackage

// File: rtl/md_busy_timer.sv
// Tracks HI/LO occupancy of the multi-cycle mult/div unit: IDLE/BUSY FSM,
// a down-counter loaded on accept, and a registered completion pulse.
module md_busy_timer
  import pipe_ctrl_pkg::*;
#(
  parameter int MD_LATENCY = 32
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      accept,
  output logic      md_done,
  output md_state_t state
);

  localparam int CW = (MD_LATENCY > 1) ? $clog2(MD_LATENCY) : 1;

  md_state_t     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          done_q, done_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  // Counter holds MD_LATENCY-1 .. 0 across the BUSY cycles; leaving at 0
  // makes the busy window exactly MD_LATENCY cycles long.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = BUSY;
          cnt_d   = CW'(MD_LATENCY - 1);
        end
      end
      BUSY: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign md_done = done_q;
  assign state   = state_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Decode-side hazard controller: load-use and HI/LO hazards, branch redirect
// priority, mult/div occupancy tracking and a saturating stall counter.
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MD_LATENCY = 32,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             id_md_start,
  input  logic             id_md_read,
  input  logic             dx_memtoreg,
  input  logic [4:0]       dx_rd,
  input  logic             ex_redirect,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             md_busy,
  output logic             md_done,
  output logic [CNT_W-1:0] stall_cnt
);

  logic             load_use;
  logic             md_hazard;
  logic             md_accept;
  logic             stall_counted;
  hazard_t          hazard_cause;
  md_state_t        md_state;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  md_busy_timer #(
    .MD_LATENCY(MD_LATENCY)
  ) u_md_timer (
    .clk    (clk),
    .rst    (rst),
    .accept (md_accept),
    .md_done(md_done),
    .state  (md_state)
  );

  assign md_busy = (md_state == BUSY);

  // r0 is never a real destination, so a load into it cannot create a hazard.
  assign load_use  = dx_memtoreg && (dx_rd != 5'd0) &&
                     ((dx_rd == id_rs) || (id_uses_rt && (dx_rd == id_rt)));
  assign md_hazard = md_busy && (id_md_read || id_md_start);

  // Redirect wins: the IF/ID instruction is wrong-path, so its hazards are moot.
  always_comb begin
    hazard_cause = HZ_NONE;
    if (ex_redirect) begin
      hazard_cause = HZ_REDIRECT;
    end else if (load_use) begin
      hazard_cause = HZ_LOAD;
    end else if (md_hazard) begin
      hazard_cause = HZ_MD;
    end
  end

  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    case (hazard_cause)
      HZ_REDIRECT: begin
        ifid_flush  = 1'b1;
        idex_bubble = 1'b1;
      end
      HZ_LOAD, HZ_MD: begin
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        idex_bubble = 1'b1;
      end
      default: ;
    endcase
  end

  assign stall_counted = (hazard_cause == HZ_LOAD) || (hazard_cause == HZ_MD);
  assign md_accept     = id_md_start && (hazard_cause == HZ_NONE);

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_counted && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: directed vectors with literal expectations
// plus a cycle-index model of hazards, HI/LO occupancy and the stall counter.
module tb_pipeline_hazard_ctrl;

  localparam int L   = 4;
  localparam int CW  = 3;
  localparam int SAT = (1 << CW) - 1;

  logic          clk;
  logic          rst;
  logic [4:0]    id_rs;
  logic [4:0]    id_rt;
  logic          id_uses_rt;
  logic          id_md_start;
  logic          id_md_read;
  logic          dx_memtoreg;
  logic [4:0]    dx_rd;
  logic          ex_redirect;
  logic          pc_write;
  logic          ifid_write;
  logic          ifid_flush;
  logic          idex_bubble;
  logic          md_busy;
  logic          md_done;
  logic [CW-1:0] stall_cnt;

  int checks = 0;
  int errors = 0;

  pipeline_hazard_ctrl #(
    .MD_LATENCY(L),
    .CNT_W     (CW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .id_rs      (id_rs),
    .id_rt      (id_rt),
    .id_uses_rt (id_uses_rt),
    .id_md_start(id_md_start),
    .id_md_read (id_md_read),
    .dx_memtoreg(dx_memtoreg),
    .dx_rd      (dx_rd),
    .ex_redirect(ex_redirect),
    .pc_write   (pc_write),
    .ifid_write (ifid_write),
    .ifid_flush (ifid_flush),
    .idex_bubble(idex_bubble),
    .md_busy    (md_busy),
    .md_done    (md_done),
    .stall_cnt  (stall_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Model: cycles are numbered by rising edges since reset release. A mult/div
  // accepted during cycle a owns HI/LO in cycles a+1..a+L and completes in a+L+1.
  int cyc     = 0;
  int acc_cyc = 0;
  bit acc_vld = 1'b0;
  int m_stall = 0;

  function automatic bit m_busy();
    return acc_vld && (cyc >= acc_cyc + 1) && (cyc <= acc_cyc + L);
  endfunction

  function automatic bit m_done();
    return acc_vld && (cyc == acc_cyc + L + 1);
  endfunction

  function automatic bit m_stall_now();
    bit lu;
    lu = dx_memtoreg && (dx_rd != 5'd0) &&
         ((dx_rd == id_rs) || (id_uses_rt && (dx_rd == id_rt)));
    return lu || (m_busy() && (id_md_read || id_md_start));
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      cyc     = 0;
      acc_vld = 1'b0;
      m_stall = 0;
    end else begin
      if (!ex_redirect && m_stall_now()) m_stall = (m_stall < SAT) ? m_stall + 1 : SAT;
      if (id_md_start && !ex_redirect && !m_stall_now()) begin
        acc_vld = 1'b1;
        acc_cyc = cyc;
      end
      cyc++;
    end
  end

  always @(negedge clk) begin
    bit st;
    bit rd;
    st = m_stall_now();
    rd = ex_redirect;
    chk("cmp_pc_write",    32'(pc_write),    32'(rd || !st));
    chk("cmp_ifid_write",  32'(ifid_write),  32'(rd || !st));
    chk("cmp_ifid_flush",  32'(ifid_flush),  32'(rd));
    chk("cmp_idex_bubble", 32'(idex_bubble), 32'(rd || st));
    chk("cmp_md_busy",     32'(md_busy),     32'(m_busy()));
    chk("cmp_md_done",     32'(md_done),     32'(m_done()));
    chk("cmp_stall_cnt",   32'(stall_cnt),   32'(m_stall));
  end

  initial begin
    int dones;
    rst = 1'b0;
    id_rs = '0; id_rt = '0; id_uses_rt = 1'b0;
    id_md_start = 1'b0; id_md_read = 1'b0;
    dx_memtoreg = 1'b0; dx_rd = '0; ex_redirect = 1'b0;
    #2;
    chk("rst_md_busy", 32'(md_busy), 32'd0);
    chk("rst_md_done", 32'(md_done), 32'd0);
    chk("rst_stall_cnt", 32'(stall_cnt), 32'd0);
    chk("rst_pc_write", 32'(pc_write), 32'd1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    step();

    // load-use on rs
    dx_memtoreg = 1'b1; dx_rd = 5'd5; id_rs = 5'd5; #1;
    chk("lu_pc_write", 32'(pc_write), 32'd0);
    chk("lu_ifid_write", 32'(ifid_write), 32'd0);
    chk("lu_bubble", 32'(idex_bubble), 32'd1);
    chk("lu_flush", 32'(ifid_flush), 32'd0);
    step();
    dx_memtoreg = 1'b0; #1;
    chk("lu_release", 32'(pc_write), 32'd1);
    chk("lu_cnt", 32'(stall_cnt), 32'd1);

    // rt gating and r0
    dx_memtoreg = 1'b1; dx_rd = 5'd7; id_rs = 5'd3; id_rt = 5'd7; id_uses_rt = 1'b0; #1;
    chk("rt_gated", 32'(pc_write), 32'd1);
    id_uses_rt = 1'b1; #1;
    chk("rt_used", 32'(pc_write), 32'd0);
    dx_rd = 5'd0; id_rs = 5'd0; id_rt = 5'd0; #1;
    chk("r0_pc_write", 32'(pc_write), 32'd1);
    chk("r0_bubble", 32'(idex_bubble), 32'd0);
    step();
    chk("r0_cnt", 32'(stall_cnt), 32'd1);

    // redirect over a load-use stall
    id_uses_rt = 1'b0; dx_rd = 5'd5; id_rs = 5'd5; ex_redirect = 1'b1; #1;
    chk("rd_flush", 32'(ifid_flush), 32'd1);
    chk("rd_bubble", 32'(idex_bubble), 32'd1);
    chk("rd_pc_write", 32'(pc_write), 32'd1);
    chk("rd_ifid_write", 32'(ifid_write), 32'd1);
    step();
    chk("rd_cnt", 32'(stall_cnt), 32'd1);
    dx_memtoreg = 1'b0; dx_rd = '0; id_rs = '0; ex_redirect = 1'b0;

    // squashed mult/div start
    id_md_start = 1'b1; ex_redirect = 1'b1;
    step();
    chk("sq_busy", 32'(md_busy), 32'd0);
    id_md_start = 1'b0; ex_redirect = 1'b0;
    step();
    chk("sq_busy2", 32'(md_busy), 32'd0);
    chk("sq_done", 32'(md_done), 32'd0);

    // mult then mflo
    id_md_start = 1'b1; #1;
    chk("mult_issue", 32'(pc_write), 32'd1);
    step();
    id_md_start = 1'b0; id_md_read = 1'b1;
    for (int i = 0; i < L; i++) begin
      #1;
      chk("mflo_busy", 32'(md_busy), 32'd1);
      chk("mflo_stall", 32'(pc_write), 32'd0);
      chk("mflo_nodone", 32'(md_done), 32'd0);
      step();
    end
    #1;
    chk("mflo_done", 32'(md_done), 32'd1);
    chk("mflo_idle", 32'(md_busy), 32'd0);
    chk("mflo_go", 32'(pc_write), 32'd1);
    chk("mflo_cnt", 32'(stall_cnt), 32'd5);

    // back-to-back start in the done cycle
    id_md_read = 1'b0; id_md_start = 1'b1; #1;
    chk("b2b_go", 32'(pc_write), 32'd1);
    step();
    id_md_start = 1'b0; #1;
    chk("b2b_busy", 32'(md_busy), 32'd1);
    chk("b2b_nodone", 32'(md_done), 32'd0);
    step();

    // asynchronous reset mid-BUSY
    #2;
    rst = 1'b0;
    #1;
    chk("arst_busy", 32'(md_busy), 32'd0);
    chk("arst_done", 32'(md_done), 32'd0);
    chk("arst_cnt", 32'(stall_cnt), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    dones = 0;
    repeat (8) begin
      step();
      if (md_done) dones++;
    end
    chk("arst_no_done", 32'(dones), 32'd0);

    // counter saturation
    dx_memtoreg = 1'b1; dx_rd = 5'd9; id_rs = 5'd9;
    repeat (SAT + 2) step();
    chk("sat_cnt", 32'(stall_cnt), 32'(SAT));
    dx_memtoreg = 1'b0;
    step();
    chk("sat_hold", 32'(stall_cnt), 32'(SAT));
    chk("sat_run", 32'(pc_write), 32'd1);

    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
